// File: rtl/spinnaker_fpgas_spi_reg_master.sv
// SPI-slave (mode 0) front end that masters the control/diagnostic register bank.
// Frame: 8-bit command, 16-bit address, 32-bit data, MSB first. SPI pins are oversampled on CLK_IN.
module spinnaker_fpgas_spi_reg_master #(
  parameter int REGA_BITS = 14,
  parameter int REGD_BITS = 32
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_N_IN,
  input  logic                 SPI_SCLK_IN,
  input  logic                 SPI_SS_IN,
  input  logic                 SPI_MOSI_IN,
  output logic                 SPI_MISO_OUT,
  output logic                 WRITE_OUT,
  output logic [REGA_BITS-1:0] ADDR_OUT,
  output logic [REGD_BITS-1:0] WRITE_DATA_OUT,
  input  logic [REGD_BITS-1:0] READ_DATA_IN
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, LOAD, DATA, WRITE, DONE} state_e;

  logic [2:0] sclk_q;
  logic [1:0] ss_q, mosi_q;
  logic       sclk_rise, sclk_fall, ss_s, mosi_s;

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d, cnt_inc;
  logic [31:0]           rx_sr_q, rx_sr_d, rx_shift;
  logic [REGD_BITS-1:0]  tx_sr_q, tx_sr_d;
  logic                  miso_q, miso_d;
  logic                  wr_q, wr_d;
  logic                  rise_seen_q, rise_seen_d;
  logic                  armed_q, armed_d;
  logic [REGA_BITS-1:0]  addr_q, addr_d;
  logic [REGD_BITS-1:0]  wdata_q, wdata_d;

  // SS synchronizer resets low so a frame already in flight at reset
  // cannot start until SS has genuinely been seen high (armed_q).
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      sclk_q <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], SPI_SCLK_IN};
      ss_q   <= {ss_q[0], SPI_SS_IN};
      mosi_q <= {mosi_q[0], SPI_MOSI_IN};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_s      = ss_q[1];
  assign mosi_s    = mosi_q[1];
  assign rx_shift  = {rx_sr_q[30:0], mosi_s};
  assign cnt_inc   = cnt_q + 6'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    wr_d        = wr_q;
    rise_seen_d = rise_seen_q;
    armed_d     = armed_q | ss_s;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if (ss_s && state_q != WRITE) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d      = 1'b0;
          cnt_d       = '0;
          rx_sr_d     = '0;
          rise_seen_d = 1'b0;
          if (armed_q) state_d = CMD;
        end
        CMD: if (sclk_rise) begin
          cnt_d   = cnt_inc;
          rx_sr_d = rx_shift;
          if (cnt_inc == 6'd8) begin
            wr_d = (rx_shift[7:0] == 8'h01);
            if (rx_shift[7:1] == 7'd0) state_d = ADDR;
            else                       state_d = DONE;
          end
        end
        ADDR: if (sclk_rise) begin
          cnt_d   = cnt_inc;
          rx_sr_d = rx_shift;
          if (cnt_inc == 6'd24) begin
            addr_d  = rx_shift[REGA_BITS-1:0];
            state_d = wr_q ? DATA : LOAD;
          end
        end
        LOAD: begin
          tx_sr_d     = READ_DATA_IN;
          miso_d      = READ_DATA_IN[REGD_BITS-1];
          rise_seen_d = 1'b0;
          state_d     = DATA;
        end
        DATA: begin
          if (sclk_rise) begin
            cnt_d       = cnt_inc;
            rx_sr_d     = rx_shift;
            rise_seen_d = 1'b1;
            if (cnt_inc == 6'd56) begin
              if (wr_q) begin
                wdata_d = rx_shift[REGD_BITS-1:0];
                state_d = WRITE;
              end else begin
                miso_d  = 1'b0;
                state_d = DONE;
              end
            end
          end else if (sclk_fall && rise_seen_q && !wr_q) begin
            // Present the next read bit only after the master sampled the current one.
            tx_sr_d     = {tx_sr_q[REGD_BITS-2:0], 1'b0};
            miso_d      = tx_sr_q[REGD_BITS-2];
            rise_seen_d = 1'b0;
          end
        end
        WRITE: state_d = DONE;
        DONE:  miso_d  = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      wr_q        <= 1'b0;
      rise_seen_q <= 1'b0;
      armed_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      wr_q        <= wr_d;
      rise_seen_q <= rise_seen_d;
      armed_q     <= armed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign SPI_MISO_OUT   = miso_q;
  assign WRITE_OUT      = (state_q == WRITE);
  assign ADDR_OUT       = addr_q;
  assign WRITE_DATA_OUT = wdata_q;

endmodule

// File: tb/tb_spinnaker_fpgas_spi_reg_master.sv
// Directed bench for the SPI register master: write, read, abort, bad command,
// mid-frame reset, overlong and back-to-back frames.
module tb_spinnaker_fpgas_spi_reg_master;
  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic          miso, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;

  int n_chk = 0, n_err = 0;
  int wr_pulses = 0, miso_hi = 0;
  int wr0, mh0;
  logic [31:0] rd;
  logic [63:0] v;

  always #5 clk = ~clk;

  spinnaker_fpgas_spi_reg_master #(.REGA_BITS(AW), .REGD_BITS(DW)) dut (
    .CLK_IN(clk), .RESET_N_IN(rst_n), .SPI_SCLK_IN(sclk), .SPI_SS_IN(ss),
    .SPI_MOSI_IN(mosi), .SPI_MISO_OUT(miso), .WRITE_OUT(wr), .ADDR_OUT(addr),
    .WRITE_DATA_OUT(wdata), .READ_DATA_IN(rdata)
  );

  // Register bank model: address 5 holds the read pattern.
  assign rdata = (addr == 14'd5) ? 32'h12345678 : {18'h2A5A5, addr};

  always @(negedge clk) begin
    if (wr)   wr_pulses++;
    if (miso) miso_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bits go out MSB first from v[63]; MISO is sampled just before each data-phase rise.
  task automatic send(input logic [63:0] vec, input int n, output logic [31:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk) mosi = vec[63-i];
      repeat (9) @(negedge clk);
      if (i >= 24 && i < 56) r = {r[30:0], miso};
      sclk = 1'b1;
      repeat (10) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic ss_lo();
    @(negedge clk) ss = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic ss_hi(input int gap);
    repeat (10) @(negedge clk);
    ss = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame(input logic [63:0] vec, input int n, input int gap, output logic [31:0] r);
    ss_lo();
    send(vec, n, r);
    ss_hi(gap);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_write", {31'd0, wr}, 32'd0);
    chk("rst_addr", {18'd0, addr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Plain write
    wr0 = wr_pulses; mh0 = miso_hi;
    frame({8'h01, 16'h0002, 32'hDEADBEEF, 8'h00}, 56, 10, rd);
    chk("wr_pulses", wr_pulses - wr0, 1);
    chk("wr_addr", {18'd0, addr}, 32'd2);
    chk("wr_wdata", wdata, 32'hDEADBEEF);
    chk("wr_miso", miso_hi - mh0, 0);

    // Read from address 5
    wr0 = wr_pulses;
    frame({8'h00, 16'h0005, 32'h00000000, 8'h00}, 56, 10, rd);
    chk("rd_data", rd, 32'h12345678);
    chk("rd_nowrite", wr_pulses - wr0, 0);
    chk("rd_addr", {18'd0, addr}, 32'd5);

    // Abort after 40 bits: address already committed, data not
    wr0 = wr_pulses;
    frame({8'h01, 16'h0009, 32'h11111111, 8'h00}, 40, 10, rd);
    chk("abort_nowrite", wr_pulses - wr0, 0);
    chk("abort_wdata", wdata, 32'hDEADBEEF);
    chk("abort_addr", {18'd0, addr}, 32'd9);
    wr0 = wr_pulses;
    frame({8'h01, 16'h0006, 32'h0BADF00D, 8'h00}, 56, 10, rd);
    chk("post_abort_pulses", wr_pulses - wr0, 1);
    chk("post_abort_wdata", wdata, 32'h0BADF00D);

    // Bad command
    wr0 = wr_pulses; mh0 = miso_hi;
    frame({8'h80, 16'hFFFF, 32'hFFFFFFFF, 8'h00}, 56, 10, rd);
    chk("badcmd_nowrite", wr_pulses - wr0, 0);
    chk("badcmd_addr", {18'd0, addr}, 32'd6);
    chk("badcmd_miso", miso_hi - mh0, 0);

    // Reset during the address phase; rest of that frame must be ignored
    wr0 = wr_pulses;
    v = {8'h01, 16'h0007, 32'h77777777, 8'h00};
    ss_lo();
    send(v, 12, rd);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mrst_miso", {31'd0, miso}, 32'd0);
    chk("mrst_write", {31'd0, wr}, 32'd0);
    chk("mrst_addr", {18'd0, addr}, 32'd0);
    chk("mrst_wdata", wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send({v[51:0], 12'h000}, 44, rd);
    ss_hi(10);
    chk("mrst_ignored_wr", wr_pulses - wr0, 0);
    chk("mrst_ignored_addr", {18'd0, addr}, 32'd0);
    chk("mrst_ignored_wdata", wdata, 32'd0);
    wr0 = wr_pulses;
    frame({8'h01, 16'h0003, 32'hCAFEF00D, 8'h00}, 56, 10, rd);
    chk("mrst_next_pulses", wr_pulses - wr0, 1);
    chk("mrst_next_addr", {18'd0, addr}, 32'd3);
    chk("mrst_next_wdata", wdata, 32'hCAFEF00D);

    // Overlong frame, then a back-to-back write with a 4-cycle SS gap
    wr0 = wr_pulses;
    frame({8'h01, 16'h0001, 32'h55AA55AA, 8'hFF}, 64, 4, rd);
    chk("long_pulses", wr_pulses - wr0, 1);
    chk("long_wdata", wdata, 32'h55AA55AA);
    wr0 = wr_pulses;
    frame({8'h01, 16'h0004, 32'hFFFFFFFF, 8'h00}, 56, 10, rd);
    chk("b2b_pulses", wr_pulses - wr0, 1);
    chk("b2b_addr", {18'd0, addr}, 32'd4);
    chk("b2b_wdata", wdata, 32'hFFFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
